// File: rtl/mdu_hilo_unit_if.sv
// Bus between the EX stage and the multiply/divide unit.
// The EX stage drives operands and commands; the unit returns status and the HI/LO registers.
interface mdu_hilo_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mt_hi;
  logic             mt_lo;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, mt_hi, mt_lo,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b, mt_hi, mt_lo,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/mdu_hilo_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Works on operand magnitudes for WIDTH clocks, then sign-corrects and commits HI/LO.
module mdu_hilo_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic            clk,
  input logic            rst_n,
  mdu_hilo_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   opnd_q;
  logic               is_div_q, neg_q_q, neg_r_q, dz_q;
  logic [WIDTH-1:0]   hi_q, lo_q;

  logic               accept, mt_ok, last;
  logic               a_neg, b_neg, op_is_div;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     mul_sum, div_shift;
  logic               div_fits;
  logic [WIDTH-1:0]   div_diff;
  logic [2*WIDTH-1:0] step_next, prod_s;
  logic [WIDTH-1:0]   res_hi, res_lo;

  assign accept = bus.start && (state_q == IDLE || state_q == FIN);
  assign mt_ok  = (state_q == IDLE) && !bus.start;
  assign last   = (cnt_q == CNT_W'(WIDTH - 1));

  assign bus.busy        = (state_q == RUN);
  assign bus.done        = (state_q == FIN);
  assign bus.div_by_zero = (state_q == FIN) && dz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FIN accepts a new Start directly so back-to-back ops cost WIDTH+1 cycles.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last) state_d = FIN;
      FIN:     state_d = bus.start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // acc holds {0, multiplier} for multiply and {remainder, quotient} for divide.
  always_comb begin
    op_is_div = bus.op[1];
    a_neg     = !bus.op[0] && bus.a[WIDTH-1];
    b_neg     = !bus.op[0] && bus.b[WIDTH-1];
    abs_a     = a_neg ? -bus.a : bus.a;
    abs_b     = b_neg ? -bus.b : bus.b;

    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = acc_q[2*WIDTH-1:WIDTH-1];
    div_fits  = (div_shift >= {1'b0, opnd_q});
    div_diff  = div_shift[WIDTH-1:0] - opnd_q;

    if (!is_div_q)     step_next = {mul_sum, acc_q[WIDTH-1:1]};
    else if (div_fits) step_next = {div_diff, acc_q[WIDTH-2:0], 1'b1};
    else               step_next = {acc_q[2*WIDTH-2:0], 1'b0};

    prod_s = neg_q_q ? -step_next : step_next;
    if (is_div_q) begin
      res_lo = dz_q ? '1 : (neg_q_q ? -step_next[WIDTH-1:0] : step_next[WIDTH-1:0]);
      res_hi = neg_r_q ? -step_next[2*WIDTH-1:WIDTH] : step_next[2*WIDTH-1:WIDTH];
    end else begin
      res_lo = prod_s[WIDTH-1:0];
      res_hi = prod_s[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      dz_q     <= 1'b0;
    end else if (accept) begin
      cnt_q    <= '0;
      acc_q    <= op_is_div ? {{WIDTH{1'b0}}, abs_a} : {{WIDTH{1'b0}}, abs_b};
      opnd_q   <= op_is_div ? abs_b : abs_a;
      is_div_q <= op_is_div;
      neg_q_q  <= a_neg ^ b_neg;
      neg_r_q  <= a_neg;
      dz_q     <= op_is_div && (bus.b == '0);
    end else if (state_q == RUN) begin
      cnt_q <= cnt_q + CNT_W'(1);
      acc_q <= step_next;
    end
  end

  // HI/LO change only on the final iteration edge, so an aborted op leaves no partial result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (state_q == RUN && last) begin
      hi_q <= res_hi;
      lo_q <= res_lo;
    end else if (mt_ok) begin
      if (bus.mt_hi) hi_q <= bus.a;
      if (bus.mt_lo) lo_q <= bus.a;
    end
  end

endmodule

// File: tb/tb_mdu_hilo_unit.sv
// Directed-vector bench for mdu_hilo_unit with hand-computed HI/LO results.
module tb_mdu_hilo_unit;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  mdu_hilo_unit_if #(.WIDTH(32)) bus ();

  mdu_hilo_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launches one op from a point just after an edge and waits (bounded) for Done.
  task automatic do_op(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                       output int lat, output int bcnt,
                       output logic [31:0] rh, output logic [31:0] rl, output logic rdz);
    lat  = 0;
    bcnt = 0;
    bus.start = 1'b1; bus.op = o; bus.a = av; bus.b = bv;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      if (bus.busy) bcnt++;
      if (bus.done) begin
        lat = n;
        break;
      end
      @(posedge clk); #1;
    end
    rh  = bus.hi;
    rl  = bus.lo;
    rdz = bus.div_by_zero;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({bus.hi, bus.lo} !== 64'h0) begin
      errors++; $display("FAIL reset_hilo got %h expected 0", {bus.hi, bus.lo});
    end
    checks++;
    if ({bus.busy, bus.done, bus.div_by_zero} !== 3'b000) begin
      errors++; $display("FAIL reset_status got %b expected 000", {bus.busy, bus.done, bus.div_by_zero});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_multiply();
    logic [1:0]  ops [4] = '{2'b01, 2'b00, 2'b01, 2'b00};
    logic [31:0] av  [4] = '{32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000};
    logic [31:0] bv  [4] = '{32'd6, 32'd5, 32'hFFFFFFFF, 32'h80000000};
    logic [63:0] exp [4] = '{64'h0000_0000_0000_002A, 64'hFFFF_FFFF_FFFF_FFF1,
                             64'hFFFF_FFFE_0000_0001, 64'h4000_0000_0000_0000};
    int lat, bcnt;
    logic [31:0] rh, rl;
    logic rdz;
    for (int i = 0; i < 4; i++) begin
      do_op(ops[i], av[i], bv[i], lat, bcnt, rh, rl, rdz);
      checks++;
      if ({rh, rl} !== exp[i]) begin
        errors++; $display("FAIL mul%0d got %h expected %h", i, {rh, rl}, exp[i]);
      end
      checks++;
      if (lat !== 33 || bcnt !== 32 || rdz !== 1'b0) begin
        errors++; $display("FAIL mul%0d_timing got lat=%0d busy=%0d dz=%b expected 33 32 0", i, lat, bcnt, rdz);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_divide();
    logic [1:0]  ops [5] = '{2'b10, 2'b11, 2'b10, 2'b10, 2'b11};
    logic [31:0] av  [5] = '{32'hFFFFFFF9, 32'd100, 32'h80000000, 32'd7, 32'hFFFFFFFF};
    logic [31:0] bv  [5] = '{32'd2, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd1};
    logic [63:0] exp [5] = '{64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_0002_0000_000E,
                             64'h0000_0000_8000_0000, 64'h0000_0001_FFFF_FFFD,
                             64'h0000_0000_FFFF_FFFF};
    int lat, bcnt;
    logic [31:0] rh, rl;
    logic rdz;
    for (int i = 0; i < 5; i++) begin
      do_op(ops[i], av[i], bv[i], lat, bcnt, rh, rl, rdz);
      checks++;
      if ({rh, rl} !== exp[i]) begin
        errors++; $display("FAIL div%0d got hi:lo %h expected %h", i, {rh, rl}, exp[i]);
      end
      checks++;
      if (lat !== 33 || rdz !== 1'b0) begin
        errors++; $display("FAIL div%0d_timing got lat=%0d dz=%b expected 33 0", i, lat, rdz);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_div_zero();
    int lat, bcnt;
    logic [31:0] rh, rl;
    logic rdz;
    do_op(2'b11, 32'h1234, 32'h0, lat, bcnt, rh, rl, rdz);
    checks++;
    if ({rh, rl} !== 64'h0000_1234_FFFF_FFFF) begin
      errors++; $display("FAIL divu_zero got %h expected 00001234ffffffff", {rh, rl});
    end
    checks++;
    if (lat !== 33 || rdz !== 1'b1) begin
      errors++; $display("FAIL divu_zero_flag got lat=%0d dz=%b expected 33 1", lat, rdz);
    end
    @(posedge clk); #1;
    checks++;
    if ({bus.done, bus.div_by_zero} !== 2'b00) begin
      errors++; $display("FAIL dz_pulse got %b expected 00", {bus.done, bus.div_by_zero});
    end
    do_op(2'b10, 32'hFFFFFFFB, 32'h0, lat, bcnt, rh, rl, rdz);
    checks++;
    if ({rh, rl} !== 64'hFFFF_FFFB_FFFF_FFFF || rdz !== 1'b1) begin
      errors++; $display("FAIL div_zero got %h dz=%b expected fffffffbffffffff 1", {rh, rl}, rdz);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_ignore_busy();
    int lat;
    lat = 0;
    bus.start = 1'b1; bus.op = 2'b01; bus.a = 32'd7; bus.b = 32'd6;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      if (n == 10) begin
        bus.start = 1'b1; bus.op = 2'b11; bus.a = 32'hDEAD; bus.b = 32'd1; bus.mt_hi = 1'b1;
      end
      if (n == 11) begin
        bus.start = 1'b0; bus.mt_hi = 1'b0;
        checks++;
        if (bus.hi !== 32'hFFFFFFFB || bus.busy !== 1'b1) begin
          errors++; $display("FAIL busy_mthi got hi=%h busy=%b expected fffffffb 1", bus.hi, bus.busy);
        end
      end
      if (bus.done) begin
        lat = n;
        break;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (lat !== 33 || {bus.hi, bus.lo} !== 64'h0000_0000_0000_002A) begin
      errors++; $display("FAIL busy_ignore got lat=%0d hi:lo=%h expected 33 2a", lat, {bus.hi, bus.lo});
    end
    @(posedge clk); #1;
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL busy_restart got busy=%b expected 0", bus.busy);
    end
  endtask

  task automatic test_move();
    bus.a = 32'h55; bus.mt_lo = 1'b1;
    @(posedge clk); #1;
    bus.mt_lo = 1'b0;
    checks++;
    if (bus.lo !== 32'h55 || bus.hi !== 32'h0) begin
      errors++; $display("FAIL mtlo got hi=%h lo=%h expected 0 55", bus.hi, bus.lo);
    end
    bus.a = 32'h77; bus.mt_lo = 1'b1; bus.mt_hi = 1'b1;
    @(posedge clk); #1;
    bus.mt_lo = 1'b0; bus.mt_hi = 1'b0;
    checks++;
    if ({bus.hi, bus.lo} !== 64'h0000_0077_0000_0077) begin
      errors++; $display("FAIL mtboth got %h expected 0000007700000077", {bus.hi, bus.lo});
    end
    bus.start = 1'b1; bus.op = 2'b01; bus.a = 32'd2; bus.b = 32'd3; bus.mt_hi = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.mt_hi = 1'b0;
    checks++;
    if (bus.hi !== 32'h77 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL start_wins got hi=%h busy=%b expected 77 1", bus.hi, bus.busy);
    end
    for (int n = 0; n < 60 && !bus.done; n++) begin
      @(posedge clk); #1;
    end
    checks++;
    if ({bus.hi, bus.lo} !== 64'h0000_0000_0000_0006 || bus.done !== 1'b1) begin
      errors++; $display("FAIL start_wins_result got %h done=%b expected 6 1", {bus.hi, bus.lo}, bus.done);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int lat, bcnt;
    logic [31:0] rh, rl;
    logic rdz;
    do_op(2'b01, 32'd3, 32'd3, lat, bcnt, rh, rl, rdz);
    checks++;
    if (rl !== 32'd9 || lat !== 33) begin
      errors++; $display("FAIL b2b_first got lo=%h lat=%0d expected 9 33", rl, lat);
    end
    do_op(2'b11, 32'd9, 32'd2, lat, bcnt, rh, rl, rdz);
    checks++;
    if ({rh, rl} !== 64'h0000_0001_0000_0004 || lat !== 33 || bcnt !== 32) begin
      errors++; $display("FAIL b2b_second got %h lat=%0d busy=%0d expected 100000004 33 32", {rh, rl}, lat, bcnt);
    end
  endtask

  task automatic test_reset_abort();
    int lat, bcnt, seen_done;
    logic [31:0] rh, rl;
    logic rdz;
    bus.start = 1'b1; bus.op = 2'b10; bus.a = 32'd100; bus.b = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (14) begin
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || {bus.hi, bus.lo} !== 64'h0) begin
      errors++; $display("FAIL abort got busy=%b hi:lo=%h expected 0 0", bus.busy, {bus.hi, bus.lo});
    end
    seen_done = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.done) seen_done++;
    end
    rst_n = 1'b1;
    repeat (30) begin
      @(posedge clk); #1;
      if (bus.done) seen_done++;
    end
    checks++;
    if (seen_done !== 0 || {bus.hi, bus.lo} !== 64'h0) begin
      errors++; $display("FAIL abort_nodone got done_count=%0d hi:lo=%h expected 0 0", seen_done, {bus.hi, bus.lo});
    end
    do_op(2'b01, 32'd7, 32'd6, lat, bcnt, rh, rl, rdz);
    checks++;
    if ({rh, rl} !== 64'h2A || lat !== 33) begin
      errors++; $display("FAIL after_reset got %h lat=%0d expected 2a 33", {rh, rl}, lat);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
    bus.mt_hi = 1'b0; bus.mt_lo = 1'b0;
    test_reset();
    test_multiply();
    test_divide();
    test_div_zero();
    test_ignore_busy();
    test_move();
    test_back_to_back();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
